rv_prisel_pipe: RTL

Parametrised, registered priority select for reservation-station issue queues. It picks one entry from a request vector of arbitrary depth: either highest-index-wins fixed priority or, when compiled in, rotating round-robin priority. It drives a one-hot grant back to the queue in the same cycle and presents the selected entry's data, index and valid one cycle later on a valid/ready output stage. It sits between queue entry storage and the issue latch, and replaces the fixed 8/12/16-entry combinational priority mux where a pipelined, back-pressured select is needed.

---
 rtl/rv_prisel_pipe_if.sv | 30 +++
 rtl/rv_prisel_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rv_prisel_pipe_if.sv
// Select-pipe bus: request vector and entry data in, one-hot grant back, registered selection out.
// Latency: grant is combinational, selection output follows one cycle later.
// Backpressure: dout_vld/dout_rdy handshake on the output stage; grant is withheld while it stalls.
`timescale 1ns/1ps
interface rv_prisel_pipe_if #(
  parameter int q_num_entries_g = 16,
  parameter int q_dat_width_g   = 7,
  parameter int q_idx_width_g   = 4
);
  logic [0:q_num_entries_g-1]               cond;
  logic [0:q_dat_width_g*q_num_entries_g-1] din;
  logic                                     flush;
  logic [0:q_num_entries_g-1]               sel_gnt;
  logic [0:q_dat_width_g-1]                 dout;
  logic [0:q_idx_width_g-1]                 dout_idx;
  logic                                     dout_vld;
  logic                                     dout_rdy;

  // queue / consumer side
  modport master (
    output cond, din, flush, dout_rdy,
    input  sel_gnt, dout, dout_idx, dout_vld
  );

  // select pipe side
  modport slave (
    input  cond, din, flush, dout_rdy,
    output sel_gnt, dout, dout_idx, dout_vld
  );
endinterface

// File: rtl/rv_prisel_pipe.sv
// Priority select for issue queues: highest-index-wins, or rotating priority under RV_PRISEL_RR_EN.
// Latency: sel_gnt combinational (0 cycles), dout/dout_idx/dout_vld registered (1 cycle).
// Backpressure: output stage stalls while dout_vld & ~dout_rdy; no grant is issued during a stall.
`timescale 1ns/1ps
module rv_prisel_pipe #(
  parameter int q_num_entries_g = 16,
  parameter int q_dat_width_g   = 7,
  parameter int q_idx_width_g   = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  rv_prisel_pipe_if.slave io_sel
);

  localparam int N  = q_num_entries_g;
  localparam int W  = q_dat_width_g;
  localparam int IW = q_idx_width_g;
  // leaves of the select tree, padded up to a power of two
  localparam int P  = 1 << IW;

  if (q_idx_width_g != $clog2(q_num_entries_g)) begin : g_chk_idx
    $error("rv_prisel_pipe: q_idx_width_g must equal ceil(log2(q_num_entries_g))");
  end
  if (q_num_entries_g < 2 || q_num_entries_g > 32) begin : g_chk_n
    $error("rv_prisel_pipe: q_num_entries_g must lie in 2..32");
  end

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } win_t;

  // Log-depth highest-index select: each level merges node pairs, the upper
  // child wins when it holds a request. Nodes are rewritten in place; node j
  // is only written after nodes 2j and 2j+1 have been read.
  function automatic win_t f_tree(input logic [P-1:0] req);
    logic [P-1:0]  v;
    logic [IW-1:0] ix [P];
    win_t          res;
    for (int i = 0; i < P; i++) begin
      v[i]  = req[i];
      ix[i] = IW'(i);
    end
    for (int lvl = 0; lvl < IW; lvl++) begin
      for (int j = 0; j < (P >> (lvl + 1)); j++) begin
        ix[j] = v[2*j+1] ? ix[2*j+1] : ix[2*j];
        v[j]  = v[2*j+1] | v[2*j];
      end
    end
    res.vld = v[0];
    res.idx = ix[0];
    return res;
  endfunction

  logic [P-1:0]  w_req;
  win_t          w_win;
  logic          w_can_load;
  logic          w_accept;
  logic [0:W-1]  w_win_dat;
  logic [0:N-1]  w_gnt;

  logic          r_dout_vld;
  logic [0:W-1]  r_dout;
  logic [IW-1:0] r_dout_idx;

  // map the big-endian request vector onto tree leaves; pad leaves stay idle
  always_comb begin
    w_req = '0;
    for (int i = 0; i < N; i++) begin
      w_req[i] = io_sel.cond[i];
    end
  end

`ifdef RV_PRISEL_RR_EN
  logic [IW-1:0] r_ptr_q;
  logic [P-1:0]  w_req_m;
  win_t          w_win_m;
  win_t          w_win_a;

  // entries at or below the pointer go first; if none, wrap to the highest request
  always_comb begin
    w_req_m = '0;
    for (int i = 0; i < P; i++) begin
      w_req_m[i] = w_req[i] & (IW'(i) <= r_ptr_q);
    end
    w_win_m = f_tree(w_req_m);
    w_win_a = f_tree(w_req);
    w_win   = w_win_m.vld ? w_win_m : w_win_a;
  end

  // pointer moves just below the accepted entry, wrapping from 0 to N-1
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr_q <= IW'(N - 1);
    end else if (w_accept) begin
      r_ptr_q <= (w_win.idx == '0) ? IW'(N - 1) : w_win.idx - 1'b1;
    end
  end
`else
  // fixed priority: plain highest-index select
  always_comb begin
    w_win = f_tree(w_req);
  end
`endif

  // accept only when the output stage can take a new entry and not in reset/flush
  always_comb begin
    w_can_load = ~r_dout_vld | io_sel.dout_rdy;
    w_accept   = rst_b & w_can_load & w_win.vld & ~io_sel.flush;
  end

  // one-hot grant and data mux for the winning entry
  always_comb begin
    w_win_dat = '0;
    w_gnt     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win.idx == IW'(i)) begin
        w_win_dat = io_sel.din[i*W +: W];
        w_gnt[i]  = w_accept;
      end
    end
  end

  // output stage: flush kills, accept loads, an idle drain clears valid, stall holds.
  // dout/dout_idx are cleared on reset so the stage powers up at a known zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
      r_dout_idx <= '0;
    end else if (io_sel.flush) begin
      r_dout_vld <= 1'b0;
    end else if (w_accept) begin
      r_dout_vld <= 1'b1;
      r_dout     <= w_win_dat;
      r_dout_idx <= w_win.idx;
    end else if (w_can_load) begin
      r_dout_vld <= 1'b0;
    end
  end

  // drive the bus outputs
  always_comb begin
    io_sel.sel_gnt  = w_gnt;
    io_sel.dout     = r_dout;
    io_sel.dout_idx = r_dout_idx;
    io_sel.dout_vld = r_dout_vld;
  end

endmodule
